// File: rtl/dmem_llbit_resp_pkg.sv
// dmem_llbit_resp_pkg
//   Shared encodings for the MEM-stage data-memory responder: reset
//   polarity, RAM enable/write strobes, LL flag values, the valid
//   strobe level and the zero word. Also provides a small helper for
//   word-alignment checks.
package dmem_llbit_resp_pkg;

    localparam logic        RST_ENABLE  = 1'b1;
    localparam logic        RAM_WRITE   = 1'b1;
    localparam logic        RAM_UNWRITE = 1'b0;
    localparam logic        RAM_ENABLE  = 1'b1;
    localparam logic        RAM_DISABLE = 1'b0;
    localparam logic        SET_FLAG    = 1'b1;
    localparam logic        CLEAR_FLAG  = 1'b0;
    localparam logic        VALID       = 1'b1;
    localparam logic [31:0] ZERO        = '0;

    // A word access must have the two low byte-address bits clear.
    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return byte_off != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_llbit_resp_llbit_reg.sv
// llbit_reg
//   LL/SC link register: holds LLbit and the linked word index.
//   Update priority on each posedge: rst, excpt (clear), wbit (load
//   wLLbit), snoop clear (only with LL_SNOOP_EN defined), hold.
//   llAddr is captured whenever an LL sets the flag.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   wbit, wLLbit     LLbit write enable and value from MEM
//   excpt            exception/eret pulse, clears the link
//   st_en            a real (aligned, enabled, non-reset) store this cycle
//   idx              word index of the current access
//   rLLbit           registered LLbit
// Config macro: LL_SNOOP_EN enables clearing the link on a plain store
//   to the linked word.
module llbit_reg
    import dmem_llbit_resp_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wbit,
    input  logic              wLLbit,
    input  logic              excpt,
    input  logic              st_en,
    input  logic [ADDR_W-1:0] idx,
    output logic              rLLbit
);

    logic              llbit;
    logic              llbit_nxt;
    logic [ADDR_W-1:0] ll_addr;
    logic [ADDR_W-1:0] ll_addr_nxt;
    logic              snoop_hit;

`ifdef LL_SNOOP_EN
    // Only a plain store (no LLbit write this cycle) to the linked word
    // breaks the link.
    assign snoop_hit = llbit && (wbit != VALID) && st_en && (idx == ll_addr);
`else
    assign snoop_hit = 1'b0;
    logic unused_snoop;
    assign unused_snoop = ^{st_en, ll_addr};
`endif

    always_comb begin
        llbit_nxt   = llbit;
        ll_addr_nxt = ll_addr;
        if (excpt) begin
            llbit_nxt = CLEAR_FLAG;
        end else if (wbit == VALID) begin
            llbit_nxt = wLLbit;
        end else if (snoop_hit) begin
            llbit_nxt = CLEAR_FLAG;
        end
        if ((wbit == VALID) && (wLLbit == SET_FLAG)) begin
            ll_addr_nxt = idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            llbit   <= CLEAR_FLAG;
            ll_addr <= '0;
        end else begin
            llbit   <= llbit_nxt;
            ll_addr <= ll_addr_nxt;
        end
    end

    assign rLLbit = llbit;

endmodule

// File: rtl/dmem_llbit_resp.sv
// dmem_llbit_resp
//   Responder end of the MEM-stage data-memory interface. Owns the
//   word-addressed data RAM (not cleared by reset) and the LL/SC link
//   register. Loads return combinationally; stores commit on posedge.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   memCe, memWr      access enable, write strobe
//   memAddr           byte address; word index = memAddr[ADDR_W+1:2]
//   wtData            store data
//   rdData            load data (zero unless an aligned read is active)
//   wbit, wLLbit      LLbit write enable and value
//   excpt             exception/eret pulse, clears the link
//   rLLbit            registered LLbit
//   misalign          enabled access with memAddr[1:0] != 0
// Config macro: LL_SNOOP_EN (see llbit_reg).
module dmem_llbit_resp
    import dmem_llbit_resp_pkg::*;
#(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memCe,
    input  logic        memWr,
    input  logic [31:0] memAddr,
    input  logic [31:0] wtData,
    output logic [31:0] rdData,
    input  logic        wbit,
    input  logic        wLLbit,
    input  logic        excpt,
    output logic        rLLbit,
    output logic        misalign
);

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic              active;
    logic              rd_en;
    logic              wr_en;

    // Upper address bits alias onto the word array.
    assign idx = memAddr[ADDR_W+1:2];

    logic unused_addr;
    assign unused_addr = ^memAddr[31:ADDR_W+2];

    assign active   = (rst != RST_ENABLE) && (memCe == RAM_ENABLE);
    assign misalign = active && is_misaligned(memAddr[1:0]);
    assign rd_en    = active && !misalign && (memWr == RAM_UNWRITE);
    assign wr_en    = active && !misalign && (memWr == RAM_WRITE);

    assign rdData = rd_en ? mem[idx] : ZERO;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= wtData;
        end
    end

    llbit_reg #(
        .ADDR_W (ADDR_W)
    ) u_llbit (
        .clk    (clk),
        .rst    (rst),
        .wbit   (wbit),
        .wLLbit (wLLbit),
        .excpt  (excpt),
        .st_en  (wr_en),
        .idx    (idx),
        .rLLbit (rLLbit)
    );

endmodule

// File: tb/tb_dmem_llbit_resp.sv
module tb_dmem_llbit_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        memCe;
    logic        memWr;
    logic [31:0] memAddr;
    logic [31:0] wtData;
    logic [31:0] rdData;
    logic        wbit;
    logic        wLLbit;
    logic        excpt;
    logic        rLLbit;
    logic        misalign;

`ifdef LL_SNOOP_EN
    localparam bit SNOOP = 1'b1;
`else
    localparam bit SNOOP = 1'b0;
`endif

    always #5 clk = ~clk;

    dmem_llbit_resp #(
        .DEPTH  (1024),
        .ADDR_W (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .memCe    (memCe),
        .memWr    (memWr),
        .memAddr  (memAddr),
        .wtData   (wtData),
        .rdData   (rdData),
        .wbit     (wbit),
        .wLLbit   (wLLbit),
        .excpt    (excpt),
        .rLLbit   (rLLbit),
        .misalign (misalign)
    );

    typedef struct {
        bit          rst;
        bit          ce;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        bit          wbit;
        bit          wll;
        bit          ex;
    } stim_t;

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        logic        ll;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_mem [int unsigned];
    bit          m_ll;
    int unsigned m_lladdr;
    int          vectors;
    int          miscompares;

    function automatic stim_t mk(bit ce, bit wr, logic [31:0] addr, logic [31:0] wd,
                                 bit wb = 1'b0, bit wll = 1'b0, bit ex = 1'b0, bit r = 1'b0);
        stim_t s;
        s.rst = r; s.ce = ce; s.wr = wr; s.addr = addr; s.wd = wd;
        s.wbit = wb; s.wll = wll; s.ex = ex;
        return s;
    endfunction

    // Drive one cycle of stimulus and push the expected outputs:
    // combinational rdData/misalign for this cycle, rLLbit after the edge.
    task automatic apply(input stim_t s);
        exp_t        e;
        int unsigned idx;
        bit          mis;
        bit          nll;
        rst = s.rst; memCe = s.ce; memWr = s.wr; memAddr = s.addr;
        wtData = s.wd; wbit = s.wbit; wLLbit = s.wll; excpt = s.ex;
        idx   = int'(s.addr[11:2]);
        mis   = !s.rst && s.ce && (s.addr[1:0] != 2'b00);
        e.mis = mis;
        e.rd  = 32'h0;
        if (!s.rst && s.ce && !s.wr && !mis)
            e.rd = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
        if (s.rst) begin
            m_ll = 1'b0;
            m_lladdr = 0;
        end else begin
            nll = m_ll;
            if (s.ex) nll = 1'b0;
            else if (s.wbit) nll = s.wll;
            else if (SNOOP && m_ll && s.ce && s.wr && !mis && idx == m_lladdr) nll = 1'b0;
            if (s.wbit && s.wll) m_lladdr = idx;
            m_ll = nll;
            if (s.ce && s.wr && !mis) m_mem[idx] = s.wd;
        end
        e.ll = m_ll;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        stim_t v[$];
        exp_t  e;
        v.push_back(mk(1, 0, 32'h13, 32'h0, 1, 1, 0, 1));
        v.push_back(mk(1, 1, 32'h10, 32'hBAD0BAD0, 0, 0, 0, 1));
        foreach (v[i]) begin
            apply(v[i]);
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (rdData !== e.rd || misalign !== e.mis) begin
                miscompares++;
                $display("FAIL reset[%0d] rdData=%h misalign=%b expected %h %b", i, rdData, misalign, e.rd, e.mis);
            end
            @(posedge clk); #1;
            vectors++;
            if (rLLbit !== e.ll) begin
                miscompares++;
                $display("FAIL reset_ll[%0d] rLLbit=%b expected %b", i, rLLbit, e.ll);
            end
        end
    endtask

    task automatic test_store_load();
        stim_t v[$];
        exp_t  e;
        v.push_back(mk(1, 1, 32'h10, 32'hDEADBEEF));
        v.push_back(mk(1, 0, 32'h10, 32'h0));
        v.push_back(mk(0, 0, 32'h10, 32'h0));
        v.push_back(mk(1, 1, 32'h10, 32'h0BADF00D));   // read-during-write: rdData 0
        v.push_back(mk(1, 1, 32'h10, 32'hDEADBEEF));
        v.push_back(mk(1, 1, 32'h1000, 32'hA5A5A5A5)); // wraps to word 0
        v.push_back(mk(1, 1, 32'hFFC, 32'h0F0F0F0F));
        v.push_back(mk(1, 0, 32'h0, 32'h0));
        v.push_back(mk(1, 0, 32'hFFFF_FFFC, 32'h0));   // aliases last word
        v.push_back(mk(1, 0, 32'h10, 32'h0));
        foreach (v[i]) begin
            apply(v[i]);
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (rdData !== e.rd || misalign !== e.mis) begin
                miscompares++;
                $display("FAIL store_load[%0d] rdData=%h misalign=%b expected %h %b", i, rdData, misalign, e.rd, e.mis);
            end
            @(posedge clk); #1;
            vectors++;
            if (rLLbit !== e.ll) begin
                miscompares++;
                $display("FAIL store_load_ll[%0d] rLLbit=%b expected %b", i, rLLbit, e.ll);
            end
        end
    endtask

    task automatic test_misalign();
        stim_t v[$];
        exp_t  e;
        v.push_back(mk(1, 1, 32'h13, 32'h12345678));
        v.push_back(mk(1, 0, 32'h10, 32'h0));
        v.push_back(mk(1, 0, 32'h12, 32'h0));
        v.push_back(mk(1, 0, 32'h11, 32'h0, 1, 1));    // LLbit still updates
        v.push_back(mk(0, 0, 32'h11, 32'h0));          // no misalign when disabled
        v.push_back(mk(1, 1, 32'h12, 32'h77777777, 1, 0));
        v.push_back(mk(1, 0, 32'h10, 32'h0));
        foreach (v[i]) begin
            apply(v[i]);
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (rdData !== e.rd || misalign !== e.mis) begin
                miscompares++;
                $display("FAIL misalign[%0d] rdData=%h misalign=%b expected %h %b", i, rdData, misalign, e.rd, e.mis);
            end
            @(posedge clk); #1;
            vectors++;
            if (rLLbit !== e.ll) begin
                miscompares++;
                $display("FAIL misalign_ll[%0d] rLLbit=%b expected %b", i, rLLbit, e.ll);
            end
        end
    endtask

    task automatic test_llsc();
        stim_t v[$];
        exp_t  e;
        v.push_back(mk(1, 1, 32'h20, 32'h00000077));
        v.push_back(mk(1, 0, 32'h20, 32'h0, 1, 1));    // LL
        v.push_back(mk(1, 1, 32'h20, 32'h00000055, 1, 0)); // SC
        v.push_back(mk(1, 0, 32'h20, 32'h0));
        foreach (v[i]) begin
            apply(v[i]);
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (rdData !== e.rd || misalign !== e.mis) begin
                miscompares++;
                $display("FAIL llsc[%0d] rdData=%h misalign=%b expected %h %b", i, rdData, misalign, e.rd, e.mis);
            end
            @(posedge clk); #1;
            vectors++;
            if (rLLbit !== e.ll) begin
                miscompares++;
                $display("FAIL llsc_ll[%0d] rLLbit=%b expected %b", i, rLLbit, e.ll);
            end
        end
    endtask

    task automatic test_excpt();
        stim_t v[$];
        exp_t  e;
        v.push_back(mk(1, 0, 32'h20, 32'h0, 1, 1));
        v.push_back(mk(0, 0, 32'h20, 32'h0, 1, 1, 1)); // clear beats set
        v.push_back(mk(1, 0, 32'h20, 32'h0, 1, 1));
        v.push_back(mk(0, 0, 32'h0, 32'h0));           // hold
        v.push_back(mk(0, 0, 32'h0, 32'h0, 0, 0, 1));
        foreach (v[i]) begin
            apply(v[i]);
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (rdData !== e.rd || misalign !== e.mis) begin
                miscompares++;
                $display("FAIL excpt[%0d] rdData=%h misalign=%b expected %h %b", i, rdData, misalign, e.rd, e.mis);
            end
            @(posedge clk); #1;
            vectors++;
            if (rLLbit !== e.ll) begin
                miscompares++;
                $display("FAIL excpt_ll[%0d] rLLbit=%b expected %b", i, rLLbit, e.ll);
            end
        end
    endtask

    task automatic test_snoop();
        stim_t v[$];
        exp_t  e;
        v.push_back(mk(1, 1, 32'h40, 32'h00000001));
        v.push_back(mk(1, 1, 32'h44, 32'h00000002));
        v.push_back(mk(1, 0, 32'h40, 32'h0, 1, 1));
        v.push_back(mk(1, 1, 32'h44, 32'h00000003));
        v.push_back(mk(1, 1, 32'h40, 32'h00000004));
        v.push_back(mk(1, 0, 32'h40, 32'h0));
        v.push_back(mk(1, 0, 32'h44, 32'h0));
        foreach (v[i]) begin
            apply(v[i]);
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (rdData !== e.rd || misalign !== e.mis) begin
                miscompares++;
                $display("FAIL snoop[%0d] rdData=%h misalign=%b expected %h %b", i, rdData, misalign, e.rd, e.mis);
            end
            @(posedge clk); #1;
            vectors++;
            if (rLLbit !== e.ll) begin
                miscompares++;
                $display("FAIL snoop_ll[%0d] rLLbit=%b expected %b", i, rLLbit, e.ll);
            end
        end
    endtask

    task automatic test_rst_mid();
        stim_t v[$];
        exp_t  e;
        v.push_back(mk(1, 1, 32'h30, 32'h11111111));
        v.push_back(mk(1, 1, 32'h34, 32'h0000CAFE));
        v.push_back(mk(1, 0, 32'h34, 32'h0, 1, 1));
        v.push_back(mk(1, 1, 32'h30, 32'h00000BAD, 0, 0, 0, 1));
        v.push_back(mk(1, 0, 32'h30, 32'h0));
        v.push_back(mk(1, 0, 32'h34, 32'h0));
        v.push_back(mk(1, 0, 32'h10, 32'h0));
        foreach (v[i]) begin
            apply(v[i]);
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (rdData !== e.rd || misalign !== e.mis) begin
                miscompares++;
                $display("FAIL rst_mid[%0d] rdData=%h misalign=%b expected %h %b", i, rdData, misalign, e.rd, e.mis);
            end
            @(posedge clk); #1;
            vectors++;
            if (rLLbit !== e.ll) begin
                miscompares++;
                $display("FAIL rst_mid_ll[%0d] rLLbit=%b expected %b", i, rLLbit, e.ll);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t v[$];
        exp_t  e;
        for (int k = 0; k < 16; k++)
            v.push_back(mk(1, 1, 32'h100 + 32'(4 * k), $urandom));
        for (int k = 0; k < 32; k++)
            v.push_back(mk(1, 1'($urandom_range(0, 1)), 32'h100 + 32'(4 * $urandom_range(0, 15)),
                           $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           ($urandom_range(0, 7) == 0)));
        foreach (v[i]) begin
            apply(v[i]);
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (rdData !== e.rd || misalign !== e.mis) begin
                miscompares++;
                $display("FAIL back_to_back[%0d] rdData=%h misalign=%b expected %h %b", i, rdData, misalign, e.rd, e.mis);
            end
            @(posedge clk); #1;
            vectors++;
            if (rLLbit !== e.ll) begin
                miscompares++;
                $display("FAIL back_to_back_ll[%0d] rLLbit=%b expected %b", i, rLLbit, e.ll);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        m_ll = 1'b0;
        m_lladdr = 0;
        rst = 1'b1; memCe = 1'b0; memWr = 1'b0; memAddr = '0; wtData = '0;
        wbit = 1'b0; wLLbit = 1'b0; excpt = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_store_load();
        test_misalign();
        test_llsc();
        test_excpt();
        test_snoop();
        test_rst_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
